pll_lock_sequencer: RTL

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 24 ++
 rtl/pll_lock_sequencer_if.sv | 24 ++
 rtl/sync2.sv | 22 ++
 rtl/pll_lock_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 1048576;
  localparam int unsigned DEF_RETRY_MAX           = 7;

  localparam int unsigned RETRY_W = 3;
  localparam int unsigned LOL_W   = 8;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Status/control bundle between the PLL lock sequencer and its surroundings.
interface pll_lock_sequencer_if;
  import pll_seq_pkg::*;

  logic               pll_locked;
  logic               relock_req;
  logic               relock_ack;
  logic               pll_rst;
  logic               sys_reset_n;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_count;
  logic [LOL_W-1:0]   lol_count;

  modport master (
    input  pll_locked, relock_req,
    output relock_ack, pll_rst, sys_reset_n, ready, fault, retry_count, lol_count
  );

  modport slave (
    output pll_locked, relock_req,
    input  relock_ack, pll_rst, sys_reset_n, ready, fault, retry_count, lol_count
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the SDRAM PLL in reset, waits for a stable lock, then releases the
// PLL-clocked logic; retries on timeout and parks in FAULT after RETRY_MAX.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned RETRY_MAX           = DEF_RETRY_MAX
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               relock_ack,
  output logic               pll_rst,
  output logic               sys_reset_n,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [LOL_W-1:0]   lol_count
);

  localparam int unsigned MAX_PARAM = max_u(max_u(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                            max_u(LOCK_TIMEOUT_CYCLES, RETRY_MAX));
  localparam int unsigned CNT_W     = $clog2(max_u(MAX_PARAM, 2));

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(RETRY_MAX);

  logic locked_s;

  sync2 u_sync2 (
    .clk   (clk_74a),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOL_W-1:0]   lol_q, lol_d;
  logic               relock_prev_q;
  logic               relock_ack_q, relock_ack_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_reset_n_q, sys_reset_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               relock_accept;
  logic [RETRY_W-1:0] retry_inc;

  // State, shared counter and registered outputs
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      lol_q         <= '0;
      relock_prev_q <= 1'b0;
      relock_ack_q  <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      lol_q         <= lol_d;
      relock_prev_q <= relock_req;
      relock_ack_q  <= relock_ack_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  // Next state; a fresh relock request overrides any timeout or lock loss
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    lol_d         = lol_q;
    retry_inc     = retry_q + RETRY_W'(1);
    relock_accept = relock_req & ~relock_prev_q;

    if (relock_accept) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
            if (lol_q != '1) lol_d = lol_q + LOL_W'(1);
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they line up with state_q
    pll_rst_d     = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    sys_reset_n_d = (state_d == ST_RUN);
    ready_d       = (state_d == ST_RUN);
    fault_d       = (state_d == ST_FAULT);
    relock_ack_d  = relock_accept;
  end

  assign relock_ack  = relock_ack_q;
  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign lol_count   = lol_q;

endmodule
